// File: rtl/pipe_regfile_pkg.sv
// Shared definitions for the pipelined register file:
// clear-FSM state encoding and default geometry.
package rf_defs;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/rf_clear_fsm.sv
// Sequential flush controller: walks every register index once, one per cycle,
// and reports the index being cleared to the storage owner.
module rf_clear_fsm
    import rf_defs::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              in_clear,
    output logic              clr_busy
);

    clr_state_e        state;
    clr_state_e        state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;
    logic              busy_next;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_next;
            clr_idx  <= clr_idx_next;
            clr_busy <= busy_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        busy_next    = clr_busy;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                    busy_next    = 1'b1;
                end
            end
            CLEAR: begin
                clr_idx_next = clr_idx + 1'b1;
                if (&clr_idx) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_clear = (state == CLEAR);
    assign clr_we   = in_clear;
    assign clr_addr = clr_idx;

endmodule

// File: rtl/pipe_regfile.sv
// NREGS x DATA_W register file with two async read ports, write-to-read forwarding,
// a per-register pending scoreboard and a sequential clear engine.
module pipe_regfile
    import rf_defs::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pend0,
    output logic              pend1,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              in_clear;
    logic              wr_ok;
    logic              rsv_ok;

    rf_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .in_clear (in_clear),
        .clr_busy (clr_busy)
    );

    always_comb begin
        wr_ok  = wrt && !in_clear && !(ZERO_R0 != 0 && waddr == '0);
        rsv_ok = rsv && !in_clear && !(ZERO_R0 != 0 && rsv_addr == '0);
    end

    // NOTE: the array is small and must read 0 after reset, so it is reset explicitly (no RAM inference).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pending <= '0;
        end else if (clr_we) begin
            regs[clr_addr]    <= '0;
            pending[clr_addr] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[waddr]    <= wdata;
                pending[waddr] <= 1'b0;
            end
            // Issued after the write so a same-address reserve marks a new producer.
            if (rsv_ok) pending[rsv_addr] <= 1'b1;
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] addr);
        if (ZERO_R0 != 0 && addr == '0) return '0;
        if (wrt && !in_clear && waddr == addr) return wdata;
        return regs[addr];
    endfunction

    function automatic logic pend_of(input logic [ADDR_W-1:0] addr);
        if (ZERO_R0 != 0 && addr == '0) return 1'b0;
        return pending[addr] & ~(wrt && waddr == addr);
    endfunction

    always_comb begin
        rdata0 = read_data(raddr0);
        rdata1 = read_data(raddr1);
        pend0  = pend_of(raddr0);
        pend1  = pend_of(raddr1);
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench: two instances (ZERO_R0=0 and 1) share stimulus; an array-level
// reference model checks every cycle, plus directed tables and clear/reset sequences.
module tb_pipe_regfile;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wrt, rsv, clr_req;
    logic [AW-1:0] waddr, raddr0, raddr1, rsv_addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic          pd0_a, pd1_a, pd0_b, pd1_b, busy_a, busy_b;

    pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(rst), .wrt(wrt), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_a), .rdata1(rd1_a),
        .rsv(rsv), .rsv_addr(rsv_addr), .pend0(pd0_a), .pend1(pd1_a),
        .clr_req(clr_req), .clr_busy(busy_a)
    );

    pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dut_b (
        .clk(clk), .rst(rst), .wrt(wrt), .waddr(waddr), .wdata(wdata),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rd0_b), .rdata1(rd1_b),
        .rsv(rsv), .rsv_addr(rsv_addr), .pend0(pd0_b), .pend1(pd1_b),
        .clr_req(clr_req), .clr_busy(busy_b)
    );

    // Reference model: index 0 = ZERO_R0=0 instance, index 1 = ZERO_R0=1 instance.
    logic [DW-1:0] m_reg  [2][NR];
    bit            m_pend [2][NR];
    int            clear_left;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;
    logic smp_busy;

    typedef struct {
        logic          wrt;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          rsv;
        logic [AW-1:0] rsv_addr;
        logic [AW-1:0] raddr0;
        logic [AW-1:0] raddr1;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        logic          e_p0;
        logic          e_p1;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
        if (k == 1 && a == '0) return '0;
        if (wrt && clear_left == 0 && waddr == a) return wdata;
        return m_reg[k][a];
    endfunction

    function automatic logic exp_pd(input int k, input logic [AW-1:0] a);
        if (k == 1 && a == '0) return 1'b0;
        return m_pend[k][a] && !(wrt && waddr == a);
    endfunction

    task automatic model_update();
        if (!rst) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < NR; i++) begin
                    m_reg[k][i]  = '0;
                    m_pend[k][i] = 1'b0;
                end
            clear_left = 0;
        end else if (clear_left > 0) begin
            for (int k = 0; k < 2; k++) begin
                m_reg[k][NR - clear_left]  = '0;
                m_pend[k][NR - clear_left] = 1'b0;
            end
            clear_left--;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wrt && !(k == 1 && waddr == '0)) begin
                    m_reg[k][waddr]  = wdata;
                    m_pend[k][waddr] = 1'b0;
                end
                if (rsv && !(k == 1 && rsv_addr == '0)) m_pend[k][rsv_addr] = 1'b1;
            end
            if (clr_req) clear_left = NR;
        end
    endtask

    // Called just after a negedge with inputs set; checks before the posedge, then advances the model.
    task automatic cycle();
        #2;
        smp_busy = busy_a;
        if (chk_en) begin
            check("model rdata0 a", 32'(rd0_a), 32'(exp_rd(0, raddr0)));
            check("model rdata1 a", 32'(rd1_a), 32'(exp_rd(0, raddr1)));
            check("model pend0 a", 32'(pd0_a), 32'(exp_pd(0, raddr0)));
            check("model pend1 a", 32'(pd1_a), 32'(exp_pd(0, raddr1)));
            check("model busy a", 32'(busy_a), 32'(clear_left > 0));
            check("model rdata0 b", 32'(rd0_b), 32'(exp_rd(1, raddr0)));
            check("model rdata1 b", 32'(rd1_b), 32'(exp_rd(1, raddr1)));
            check("model pend0 b", 32'(pd0_b), 32'(exp_pd(1, raddr0)));
            check("model pend1 b", 32'(pd1_b), 32'(exp_pd(1, raddr1)));
            check("model busy b", 32'(busy_b), 32'(clear_left > 0));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b1; wrt = 1'b0; rsv = 1'b0; clr_req = 1'b0;
        waddr = '0; wdata = '0; rsv_addr = '0; raddr0 = '0; raddr1 = '0;
    endtask

    task automatic fill(input logic [DW-1:0] base, input bit inc);
        for (int i = 0; i < NR; i++) begin
            idle_inputs();
            wrt = 1'b1; waddr = AW'(i);
            wdata = inc ? base + DW'(i) : base;
            cycle();
        end
        idle_inputs();
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < NR / 2; i++) begin
            idle_inputs();
            raddr0 = AW'(2 * i); raddr1 = AW'(2 * i + 1);
            #1;
            check({name, " rdata0"}, 32'(rd0_a), 32'h0);
            check({name, " rdata1"}, 32'(rd1_a), 32'h0);
            cycle();
        end
    endtask

    initial begin
        int busy_cycles;

        tbl[0] = '{1'b1, 4'd3, 8'h3C, 1'b0, 4'd0, 4'd0, 4'd3, 8'h00, 8'h3C, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd0, 4'd3, 8'h00, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 4'd7, 4'd3, 8'h00, 8'h3C, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd7, 4'd3, 8'h00, 8'h3C, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 4'd7, 8'h77, 1'b0, 4'd0, 4'd7, 4'd3, 8'h77, 8'h3C, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd7, 4'd3, 8'h77, 8'h3C, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'd9, 8'h99, 1'b1, 4'd9, 4'd9, 4'd3, 8'h99, 8'h3C, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 4'd9, 4'd7, 8'h99, 8'h77, 1'b1, 1'b0};

        idle_inputs();
        rst = 1'b0;
        clear_left = 0;
        @(negedge clk);
        cycle();
        chk_en = 1'b1;

        // Reset clears data and pending state.
        idle_inputs();
        wrt = 1'b1; waddr = 4'd5; wdata = 8'hA5; rsv = 1'b1; rsv_addr = 4'd5;
        cycle();
        idle_inputs();
        raddr0 = 4'd5;
        #1;
        check("pre-reset rdata0", 32'(rd0_a), 32'hA5);
        check("pre-reset pend0", 32'(pd0_a), 32'h1);
        cycle();
        idle_inputs();
        rst = 1'b0; raddr0 = 4'd5;
        cycle();
        idle_inputs();
        raddr0 = 4'd5;
        #1;
        check("reset rdata0", 32'(rd0_a), 32'h0);
        check("reset pend0", 32'(pd0_a), 32'h0);
        check("reset clr_busy", 32'(busy_a), 32'h0);
        cycle();

        // Forwarding and scoreboard vectors.
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            wrt = tbl[i].wrt; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            rsv = tbl[i].rsv; rsv_addr = tbl[i].rsv_addr;
            raddr0 = tbl[i].raddr0; raddr1 = tbl[i].raddr1;
            #1;
            check($sformatf("vec%0d rdata0", i), 32'(rd0_a), 32'(tbl[i].e_rd0));
            check($sformatf("vec%0d rdata1", i), 32'(rd1_a), 32'(tbl[i].e_rd1));
            check($sformatf("vec%0d pend0", i), 32'(pd0_a), 32'(tbl[i].e_p0));
            check($sformatf("vec%0d pend1", i), 32'(pd1_a), 32'(tbl[i].e_p1));
            cycle();
        end

        // Full clear: busy for exactly NR cycles, writes during clear dropped.
        fill(8'hFF, 1'b0);
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            raddr0 = 4'd2; raddr1 = AW'(c);
            if (c == 3) begin wrt = 1'b1; waddr = 4'd2; wdata = 8'hAB; end
            cycle();
            if (smp_busy === 1'b1) busy_cycles++;
        end
        check("clear busy cycles", 32'(busy_cycles), 32'(NR));
        sweep_zero("after clear");

        // Reset during the sixth clear cycle, then a fresh clear starts at index 0.
        fill(8'h10, 1'b1);
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            cycle();
        end
        idle_inputs();
        rst = 1'b0;
        cycle();
        idle_inputs();
        #1;
        check("mid-clear reset busy", 32'(busy_a), 32'h0);
        sweep_zero("after mid-clear reset");
        fill(8'h10, 1'b1);
        idle_inputs();
        clr_req = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        idle_inputs();
        raddr0 = 4'd0; raddr1 = 4'd1;
        #1;
        check("restart idx0 cleared", 32'(rd0_a), 32'h0);
        check("restart idx1 intact", 32'(rd1_a), 32'h11);
        cycle();
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            cycle();
        end

        // Hard-wired zero register on the ZERO_R0 instance.
        idle_inputs();
        wrt = 1'b1; waddr = 4'd0; wdata = 8'h55; rsv = 1'b1; rsv_addr = 4'd0;
        #1;
        check("zero_r0 fwd rdata0", 32'(rd0_b), 32'h0);
        check("zero_r0 fwd pend0", 32'(pd0_b), 32'h0);
        cycle();
        idle_inputs();
        #1;
        check("zero_r0 rdata0", 32'(rd0_b), 32'h0);
        check("zero_r0 pend0", 32'(pd0_b), 32'h0);
        check("normal r0 rdata0", 32'(rd0_a), 32'h55);
        check("normal r0 pend0", 32'(pd0_a), 32'h1);
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            rst      = ($urandom_range(63) != 0);
            wrt      = 1'($urandom_range(1));
            waddr    = AW'($urandom_range(NR - 1));
            wdata    = DW'($urandom);
            rsv      = 1'($urandom_range(1));
            rsv_addr = ($urandom_range(3) == 0) ? waddr : AW'($urandom_range(NR - 1));
            raddr0   = ($urandom_range(2) == 0) ? waddr : AW'($urandom_range(NR - 1));
            raddr1   = AW'($urandom_range(NR - 1));
            clr_req  = ($urandom_range(39) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
